// File: rtl/prefix_add_arb_pkg.sv
// Shared types and constants for the round-robin prefix-adder pipeline.
// Provides the id-width helper and the S1 stage record layout.
package prefix_add_arb_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NREQ  = 4;

  // Requester index width: clog2(n), never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_IDW = id_width(DEF_NREQ);

  // S1 record at the default widths; the top declares the same layout at its own parameters.
  typedef struct packed {
    logic               valid;
    logic [DEF_IDW-1:0] id;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } stage_t;

endpackage

// File: rtl/prefix_add_arb_ks_adder.sv
// Kogge-Stone parallel prefix adder, carry-in 0, carry-out returned in the MSB.
// Each prefix level lives in its own generate scope so levels stay separate signals.
module ks_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  localparam int unsigned LVL = $clog2(WIDTH);

  for (genvar l = 0; l <= LVL; l++) begin : lvl
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    if (l == 0) begin : base
      assign g = a_i & b_i;
      assign p = a_i ^ b_i;
    end else begin : comb
      for (genvar i = 0; i < WIDTH; i++) begin : bitpos
        if (i >= (1 << (l - 1))) begin : op
          assign g[i] = lvl[l-1].g[i] | (lvl[l-1].p[i] & lvl[l-1].g[i-(1<<(l-1))]);
          assign p[i] = lvl[l-1].p[i] & lvl[l-1].p[i-(1<<(l-1))];
        end else begin : pass
          assign g[i] = lvl[l-1].g[i];
          assign p[i] = lvl[l-1].p[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] gn;
  logic             unused_p;

  assign p0       = lvl[0].p;
  assign gn       = lvl[LVL].g;
  assign unused_p = ^lvl[LVL].p;

  // Carry into bit i is the group generate of bits [i-1:0].
  assign sum_o = {gn[WIDTH-1], p0 ^ {gn[WIDTH-2:0], 1'b0}};

endmodule

// File: rtl/prefix_add_arb_rr_arbiter.sv
// Round-robin grant: searches from ptr_i+1 (mod NREQ) for the first active request.
// idx_o is the winner whenever any request is active; gnt_o is gated by en_i.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    // NOTE: every signal this block writes gets a default first, so no latch is inferred.
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(ptr_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    if (found && en_i) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/prefix_add_arb.sv
// NREQ requesters share one two-stage add pipeline through a round-robin arbiter.
// S1 holds granted operands, S2 holds the Kogge-Stone sum; both stall under back-pressure.
module prefix_add_arb
  import prefix_add_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREQ  = DEF_NREQ
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid_i,
  output logic [NREQ-1:0]             req_ready_o,
  input  logic [NREQ*WIDTH-1:0]       req_a_i,
  input  logic [NREQ*WIDTH-1:0]       req_b_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [id_width(NREQ)-1:0]   rsp_id_o,
  output logic [WIDTH:0]              rsp_sum_o
);

  localparam int unsigned IDW = id_width(NREQ);

  typedef struct packed {
    logic             valid;
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  s1_t              s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [IDW-1:0]   s2_id_q, s2_id_d;
  logic [WIDTH:0]   s2_sum_q, s2_sum_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;

  logic             s2_load, s1_load, arb_en, req_xfer;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH:0]   add_sum;

  assign s2_load  = !s2_valid_q || rsp_ready_i;
  assign s1_load  = !s1_q.valid || s2_load;
  // Reset also masks grants so req_ready is quiet while rst_n is low.
  assign arb_en   = s1_load && rst_n;
  assign req_xfer = |gnt;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (last_grant_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  ks_adder #(.WIDTH(WIDTH)) u_add (
    .a_i   (s1_q.a),
    .b_i   (s1_q.b),
    .sum_o (add_sum)
  );

  // One-hot operand mux driven by the grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i]) begin
        sel_a = req_a_i[i*WIDTH +: WIDTH];
        sel_b = req_b_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    s1_d         = s1_q;
    last_grant_d = last_grant_q;
    s2_valid_d   = s2_valid_q;
    s2_id_d      = s2_id_q;
    s2_sum_d     = s2_sum_q;

    if (s1_load) begin
      s1_d.valid = req_xfer;
      if (req_xfer) begin
        s1_d.id      = gnt_idx;
        s1_d.a       = sel_a;
        s1_d.b       = sel_b;
        last_grant_d = gnt_idx;
      end
    end

    if (s2_load) begin
      s2_valid_d = s1_q.valid;
      if (s1_q.valid) begin
        s2_id_d  = s1_q.id;
        s2_sum_d = add_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      s2_id_q      <= '0;
      s2_sum_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values and stages shift cleanly.
      s1_q         <= s1_d;
      s2_valid_q   <= s2_valid_d;
      s2_id_q      <= s2_id_d;
      s2_sum_q     <= s2_sum_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req_ready_o = gnt;
  assign rsp_valid_o = s2_valid_q;
  assign rsp_id_o    = s2_id_q;
  assign rsp_sum_o   = s2_sum_q;

endmodule

// File: tb/tb_prefix_add_arb.sv
// Scoreboard bench for prefix_add_arb (WIDTH=16, NREQ=4): directed stimulus pushes
// hand-computed responses; a negedge monitor pops and compares on each response transfer.
module tb_prefix_add_arb;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [WIDTH:0]        rsp_sum;

  typedef struct {
    logic [1:0]     id;
    logic [WIDTH:0] sum;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  prefix_add_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [WIDTH:0] sum);
    exp_t e;
    e.id  = id;
    e.sum = sum;
    exp_q.push_back(e);
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present req_valid for one cycle, check the combinational grant, then cross the edge.
  task automatic issue(input logic [3:0] v, input logic [3:0] exp_rdy, input string nm);
    req_valid = v;
    #1;
    check(nm, 32'(req_ready), 32'(exp_rdy));
    tick();
  endtask

  // Monitor: a response transfer happens at the next rising edge when both flags are high.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id",    32'(rsp_id),    32'd0);
    check("reset_rsp_sum",   32'(rsp_sum),   32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;

    // Single request on requester 0; result visible two edges after it is presented.
    set_op(0, 16'h1234, 16'h0001);
    push(2'd0, 17'h01235);
    issue(4'b0001, 4'b0001, "single_rdy");
    req_valid = 4'b0000;
    #1;
    check("latency_edge1_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("latency_edge2_rsp_valid", 32'(rsp_valid), 32'd1);

    // Overflow on requester 2 keeps the carry-out.
    set_op(2, 16'hFFFF, 16'h0001);
    push(2'd2, 17'h10000);
    issue(4'b0100, 4'b0100, "ovf_rdy");

    // Requester 3 alone, leaving last_grant=3 so the next sweep starts at 0.
    set_op(3, 16'h00FF, 16'h0F01);
    push(2'd3, 17'h01000);
    issue(4'b1000, 4'b1000, "prime_rdy");

    // Round-robin with all four requesters valid: grants 0,1,2,3,0 back to back.
    set_op(0, 16'h1111, 16'h0001);
    set_op(1, 16'h2222, 16'h0002);
    set_op(2, 16'hF000, 16'h1000);
    set_op(3, 16'hABCD, 16'h5432);
    push(2'd0, 17'h01112);
    push(2'd1, 17'h02224);
    push(2'd2, 17'h10000);
    push(2'd3, 17'h0FFFF);
    push(2'd0, 17'h01112);
    for (int k = 0; k < 5; k++) issue(4'b1111, 4'(1 << (k % 4)), "rr_rdy");
    req_valid = 4'b0000;
    repeat (3) tick();
    check("rr_drained", 32'(rsp_valid), 32'd0);

    // Back-pressure: requesters 1 and 3 valid, rsp_ready low for five cycles.
    rsp_ready = 1'b0;
    set_op(1, 16'h7FFF, 16'h0001);
    set_op(3, 16'hFFFF, 16'hFFFF);
    push(2'd1, 17'h08000);
    push(2'd3, 17'h1FFFE);
    issue(4'b1010, 4'b0010, "bp_rdy_first");
    issue(4'b1010, 4'b1000, "bp_rdy_second");
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b1010;
      #1;
      check("bp_rdy_stall",   32'(req_ready), 32'd0);
      check("bp_id_stable",   32'(rsp_id),    32'd1);
      check("bp_sum_stable",  32'(rsp_sum),   32'h08000);
      tick();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    repeat (3) tick();
    check("bp_drained", 32'(rsp_valid), 32'd0);

    // Idle gaps: requester 1 every other cycle, then all valid proves last_grant held at 1.
    set_op(1, 16'hAAAA, 16'h5555);
    push(2'd1, 17'h0FFFF);
    issue(4'b0010, 4'b0010, "idle_rdy0");
    issue(4'b0000, 4'b0000, "idle_gap0");
    set_op(1, 16'h1000, 16'h0234);
    push(2'd1, 17'h01234);
    issue(4'b0010, 4'b0010, "idle_rdy1");
    issue(4'b0000, 4'b0000, "idle_gap1");
    set_op(1, 16'h8001, 16'h8001);
    push(2'd1, 17'h10002);
    issue(4'b0010, 4'b0010, "idle_rdy2");
    issue(4'b0000, 4'b0000, "idle_gap2");
    set_op(2, 16'hF000, 16'h1000);
    push(2'd2, 17'h10000);
    issue(4'b1111, 4'b0100, "idle_ptr_kept");
    req_valid = 4'b0000;
    repeat (3) tick();

    // Mid-operation reset with both stages full: nothing in flight may emerge.
    rsp_ready = 1'b0;
    issue(4'b0001, 4'b0001, "rst_fill0");
    issue(4'b0001, 4'b0001, "rst_fill1");
    check("rst_pre_full", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_sum",   32'(rsp_sum),   32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    set_op(0, 16'h4321, 16'h1234);
    push(2'd0, 17'h05555);
    issue(4'b1111, 4'b0001, "rst_first_grant");
    req_valid = 4'b0000;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
